// File: rtl/store_buffer_fwd_if.sv
// Signal bundle between the store buffer, the LSU/MMU push side, the dcache drain
// side and the load forwarding lookup.
interface store_buffer_fwd_if #(
   parameter int BLEN           = 4,
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int BYTE_SEL_WIDTH = DATA_WIDTH / 8
);
   localparam int CNT_W = $clog2(BLEN) + 1;

   logic                      lsummu2stb_req;
   logic [ADDR_WIDTH-1:0]     lsummu2stb_addr;
   logic [DATA_WIDTH-1:0]     lsummu2stb_wdata;
   logic [BYTE_SEL_WIDTH-1:0] lsummu2stb_sel_byte;
   logic                      lsummu2stb_fence;
   logic                      stb2lsummu_ready;
   logic                      stb2lsummu_fence_done;

   logic                      stb2dcache_req;
   logic [ADDR_WIDTH-1:0]     stb2dcache_addr;
   logic [DATA_WIDTH-1:0]     stb2dcache_wdata;
   logic [BYTE_SEL_WIDTH-1:0] stb2dcache_sel_byte;
   logic                      dcache2stb_ack;

   logic [ADDR_WIDTH-1:0]     lsu2stb_ld_addr;
   logic [BYTE_SEL_WIDTH-1:0] lsu2stb_ld_sel_byte;
   logic [DATA_WIDTH-1:0]     stb2lsu_fwd_data;
   logic [BYTE_SEL_WIDTH-1:0] stb2lsu_fwd_mask;
   logic                      stb2lsu_fwd_hit;

   logic                      stb_full;
   logic                      stb_empty;
   logic [CNT_W-1:0]          stb_count;

   modport master (
      output lsummu2stb_req, lsummu2stb_addr, lsummu2stb_wdata, lsummu2stb_sel_byte,
             lsummu2stb_fence, dcache2stb_ack, lsu2stb_ld_addr, lsu2stb_ld_sel_byte,
      input  stb2lsummu_ready, stb2lsummu_fence_done, stb2dcache_req, stb2dcache_addr,
             stb2dcache_wdata, stb2dcache_sel_byte, stb2lsu_fwd_data, stb2lsu_fwd_mask,
             stb2lsu_fwd_hit, stb_full, stb_empty, stb_count
   );

   modport slave (
      input  lsummu2stb_req, lsummu2stb_addr, lsummu2stb_wdata, lsummu2stb_sel_byte,
             lsummu2stb_fence, dcache2stb_ack, lsu2stb_ld_addr, lsu2stb_ld_sel_byte,
      output stb2lsummu_ready, stb2lsummu_fence_done, stb2dcache_req, stb2dcache_addr,
             stb2dcache_wdata, stb2dcache_sel_byte, stb2lsu_fwd_data, stb2lsu_fwd_mask,
             stb2lsu_fwd_hit, stb_full, stb_empty, stb_count
   );
endinterface

// File: rtl/store_buffer_fwd.sv
// Circular store buffer with concurrent push/pop, req/ack drain to dcache, fence
// drain mode and same-cycle per-byte youngest-wins store-to-load forwarding.
module store_buffer_fwd #(
   parameter int BLEN           = 4,
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int BYTE_SEL_WIDTH = DATA_WIDTH / 8
) (
   input  logic              clk,
   input  logic              rst_n,
   store_buffer_fwd_if.slave stb_if
);
   localparam int PTR_W = $clog2(BLEN);
   localparam int CNT_W = PTR_W + 1;
   localparam int OFS   = $clog2(BYTE_SEL_WIDTH);

   logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]          count_q, count_d;
   logic [BLEN-1:0]           valid_q, valid_d;
   logic [ADDR_WIDTH-1:0]     ent_addr_q [BLEN];
   logic [ADDR_WIDTH-1:0]     ent_addr_d [BLEN];
   logic [DATA_WIDTH-1:0]     ent_data_q [BLEN];
   logic [DATA_WIDTH-1:0]     ent_data_d [BLEN];
   logic [BYTE_SEL_WIDTH-1:0] ent_sel_q  [BLEN];
   logic [BYTE_SEL_WIDTH-1:0] ent_sel_d  [BLEN];

   logic                      full, empty, ready, push, pop;
   logic [PTR_W-1:0]          ent_idx;
   logic [BYTE_SEL_WIDTH-1:0] found_mask, fwd_mask;
   logic [DATA_WIDTH-1:0]     found_data, fwd_data;

   assign full  = (count_q == CNT_W'(BLEN));
   assign empty = (count_q == '0);
   assign ready = !full && !stb_if.lsummu2stb_fence;
   assign push  = stb_if.lsummu2stb_req && ready;
   assign pop   = !empty && stb_if.dcache2stb_ack;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= '0;
         for (int i = 0; i < BLEN; i++) begin
            ent_addr_q[i] <= '0;
            ent_data_q[i] <= '0;
            ent_sel_q[i]  <= '0;
         end
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         valid_q    <= valid_d;
         ent_addr_q <= ent_addr_d;
         ent_data_q <= ent_data_d;
         ent_sel_q  <= ent_sel_d;
      end
   end

   // Push and pop never target the same slot: that needs count 0 (no pop) or BLEN (no push).
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      valid_d    = valid_q;
      ent_addr_d = ent_addr_q;
      ent_data_d = ent_data_q;
      ent_sel_d  = ent_sel_q;
      if (push) begin
         ent_addr_d[wr_ptr_q] = stb_if.lsummu2stb_addr;
         ent_data_d[wr_ptr_q] = stb_if.lsummu2stb_wdata;
         ent_sel_d[wr_ptr_q]  = stb_if.lsummu2stb_sel_byte;
         valid_d[wr_ptr_q]    = 1'b1;
         wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         valid_d[rd_ptr_q] = 1'b0;
         rd_ptr_d          = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Walk oldest to youngest so later matches overwrite earlier ones byte by byte.
   always_comb begin
      found_mask = '0;
      found_data = '0;
      ent_idx    = rd_ptr_q;
      for (int i = 0; i < BLEN; i++) begin
         ent_idx = rd_ptr_q + PTR_W'(i);
         if (valid_q[ent_idx] &&
             ent_addr_q[ent_idx][ADDR_WIDTH-1:OFS] == stb_if.lsu2stb_ld_addr[ADDR_WIDTH-1:OFS]) begin
            for (int b = 0; b < BYTE_SEL_WIDTH; b++) begin
               if (ent_sel_q[ent_idx][b]) begin
                  found_mask[b]        = 1'b1;
                  found_data[8*b +: 8] = ent_data_q[ent_idx][8*b +: 8];
               end
            end
         end
      end
   end

   always_comb begin
      fwd_mask = found_mask & stb_if.lsu2stb_ld_sel_byte;
      fwd_data = '0;
      for (int b = 0; b < BYTE_SEL_WIDTH; b++) begin
         if (fwd_mask[b]) fwd_data[8*b +: 8] = found_data[8*b +: 8];
      end
   end

   assign stb_if.stb2lsummu_ready      = ready;
   assign stb_if.stb2lsummu_fence_done = stb_if.lsummu2stb_fence && empty;
   assign stb_if.stb2dcache_req        = !empty;
   assign stb_if.stb2dcache_addr       = empty ? '0 : ent_addr_q[rd_ptr_q];
   assign stb_if.stb2dcache_wdata      = empty ? '0 : ent_data_q[rd_ptr_q];
   assign stb_if.stb2dcache_sel_byte   = empty ? '0 : ent_sel_q[rd_ptr_q];
   assign stb_if.stb2lsu_fwd_data      = fwd_data;
   assign stb_if.stb2lsu_fwd_mask      = fwd_mask;
   assign stb_if.stb2lsu_fwd_hit       = (stb_if.lsu2stb_ld_sel_byte != '0) &&
                                         (fwd_mask == stb_if.lsu2stb_ld_sel_byte);
   assign stb_if.stb_full              = full;
   assign stb_if.stb_empty             = empty;
   assign stb_if.stb_count             = count_q;
endmodule

// File: tb/tb_store_buffer_fwd.sv
// Bench for store_buffer_fwd: directed vector table, fence and async-reset sequences,
// then random traffic against a queue-based reference model.
module tb_store_buffer_fwd;
   localparam int BLEN = 4;
   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int SW   = DW / 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   store_buffer_fwd_if #(.BLEN(BLEN), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_SEL_WIDTH(SW)) bus ();

   store_buffer_fwd #(.BLEN(BLEN), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_SEL_WIDTH(SW)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .stb_if (bus.slave)
   );

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [SW-1:0] sel;
   } st_t;
   st_t model_q[$];

   typedef struct {
      logic          req;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [SW-1:0] sel;
      logic          ack;
      logic [AW-1:0] ld_addr;
      logic [SW-1:0] ld_sel;
      int            e_count;
      logic          e_ready;
      logic          e_req;
      logic [AW-1:0] e_haddr;
      logic [DW-1:0] e_hdata;
      logic [SW-1:0] e_mask;
      logic [DW-1:0] e_fdata;
      logic          e_hit;
   } vec_t;
   vec_t vecs[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void v(input logic req, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                             input logic [SW-1:0] sel, input logic ack, input logic [AW-1:0] ld_addr,
                             input logic [SW-1:0] ld_sel, input int e_count, input logic e_ready,
                             input logic e_req, input logic [AW-1:0] e_haddr, input logic [DW-1:0] e_hdata,
                             input logic [SW-1:0] e_mask, input logic [DW-1:0] e_fdata, input logic e_hit);
      vec_t t;
      t.req = req; t.addr = addr; t.wdata = wdata; t.sel = sel; t.ack = ack;
      t.ld_addr = ld_addr; t.ld_sel = ld_sel; t.e_count = e_count; t.e_ready = e_ready;
      t.e_req = e_req; t.e_haddr = e_haddr; t.e_hdata = e_hdata; t.e_mask = e_mask;
      t.e_fdata = e_fdata; t.e_hit = e_hit;
      vecs.push_back(t);
   endfunction

   // Reference forwarding: overlay every matching store from oldest to youngest.
   function automatic void model_fwd(input logic [AW-1:0] ld_addr, input logic [SW-1:0] ld_sel,
                                     output logic [SW-1:0] mask, output logic [DW-1:0] data,
                                     output logic hit);
      logic [SW-1:0] found = '0;
      logic [DW-1:0] bytes = '0;
      foreach (model_q[i]) begin
         if ((model_q[i].addr >> 2) == (ld_addr >> 2)) begin
            for (int b = 0; b < SW; b++) begin
               if (model_q[i].sel[b]) begin
                  found[b] = 1'b1;
                  bytes[8*b +: 8] = model_q[i].data[8*b +: 8];
               end
            end
         end
      end
      mask = found & ld_sel;
      data = '0;
      for (int b = 0; b < SW; b++) if (mask[b]) data[8*b +: 8] = bytes[8*b +: 8];
      hit = (ld_sel != 0) && (mask == ld_sel);
   endfunction

   task automatic drive(input logic req, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic [SW-1:0] sel, input logic fence, input logic ack,
                        input logic [AW-1:0] ld_addr, input logic [SW-1:0] ld_sel);
      bus.lsummu2stb_req      = req;
      bus.lsummu2stb_addr     = addr;
      bus.lsummu2stb_wdata    = wdata;
      bus.lsummu2stb_sel_byte = sel;
      bus.lsummu2stb_fence    = fence;
      bus.dcache2stb_ack      = ack;
      bus.lsu2stb_ld_addr     = ld_addr;
      bus.lsu2stb_ld_sel_byte = ld_sel;
   endtask

   // One model-checked cycle: drive at negedge, compare before the next posedge, advance model.
   task automatic step(input logic req, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                       input logic [SW-1:0] sel, input logic fence, input logic ack,
                       input logic [AW-1:0] ld_addr, input logic [SW-1:0] ld_sel);
      logic [SW-1:0] m_mask;
      logic [DW-1:0] m_data;
      logic          m_hit, m_ready, m_empty;
      st_t           e;
      @(negedge clk);
      drive(req, addr, wdata, sel, fence, ack, ld_addr, ld_sel);
      #1;
      m_empty = (model_q.size() == 0);
      m_ready = (model_q.size() < BLEN) && !fence;
      model_fwd(ld_addr, ld_sel, m_mask, m_data, m_hit);
      chk("ready", bus.stb2lsummu_ready, m_ready);
      chk("fence_done", bus.stb2lsummu_fence_done, fence && m_empty);
      chk("count", bus.stb_count, model_q.size());
      chk("full", bus.stb_full, model_q.size() == BLEN);
      chk("empty", bus.stb_empty, m_empty);
      chk("dc_req", bus.stb2dcache_req, !m_empty);
      chk("head_addr", bus.stb2dcache_addr, m_empty ? '0 : model_q[0].addr);
      chk("head_data", bus.stb2dcache_wdata, m_empty ? '0 : model_q[0].data);
      chk("head_sel", bus.stb2dcache_sel_byte, m_empty ? '0 : model_q[0].sel);
      chk("fwd_mask", bus.stb2lsu_fwd_mask, m_mask);
      chk("fwd_data", bus.stb2lsu_fwd_data, m_data);
      chk("fwd_hit", bus.stb2lsu_fwd_hit, m_hit);
      if (ack && !m_empty) void'(model_q.pop_front());
      if (req && m_ready) begin
         e.addr = addr; e.data = wdata; e.sel = sel;
         model_q.push_back(e);
      end
   endtask

   initial begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #12;
      chk("rst_empty", bus.stb_empty, 1);
      chk("rst_full", bus.stb_full, 0);
      chk("rst_count", bus.stb_count, 0);
      chk("rst_dc_req", bus.stb2dcache_req, 0);
      chk("rst_head_addr", bus.stb2dcache_addr, 0);
      chk("rst_fwd_mask", bus.stb2lsu_fwd_mask, 0);
      @(negedge clk);
      rst_n = 1'b1;

      //  req addr       wdata         sel  ack ld_addr    ld_sel cnt rdy req haddr      hdata         mask fdata         hit
      v(1, 32'h100, 32'hA0,        4'hF, 0, 32'h0,   4'h0, 0, 1, 0, 32'h0,   32'h0,        4'h0, 32'h0,        0);
      v(1, 32'h104, 32'hA1,        4'hF, 0, 32'h0,   4'h0, 1, 1, 1, 32'h100, 32'hA0,       4'h0, 32'h0,        0);
      v(1, 32'h108, 32'hA2,        4'hF, 0, 32'h0,   4'h0, 2, 1, 1, 32'h100, 32'hA0,       4'h0, 32'h0,        0);
      v(1, 32'h10C, 32'hA3,        4'hF, 0, 32'h0,   4'h0, 3, 1, 1, 32'h100, 32'hA0,       4'h0, 32'h0,        0);
      v(1, 32'h110, 32'hA4,        4'hF, 0, 32'h108, 4'hF, 4, 0, 1, 32'h100, 32'hA0,       4'hF, 32'hA2,       1);
      v(0, 32'h0,   32'h0,         4'h0, 1, 32'h0,   4'h0, 4, 0, 1, 32'h100, 32'hA0,       4'h0, 32'h0,        0);
      v(0, 32'h0,   32'h0,         4'h0, 1, 32'h0,   4'h0, 3, 1, 1, 32'h104, 32'hA1,       4'h0, 32'h0,        0);
      v(0, 32'h0,   32'h0,         4'h0, 1, 32'h0,   4'h0, 2, 1, 1, 32'h108, 32'hA2,       4'h0, 32'h0,        0);
      v(0, 32'h0,   32'h0,         4'h0, 1, 32'h0,   4'h0, 1, 1, 1, 32'h10C, 32'hA3,       4'h0, 32'h0,        0);
      v(0, 32'h0,   32'h0,         4'h0, 1, 32'h10C, 4'hF, 0, 1, 0, 32'h0,   32'h0,        4'h0, 32'h0,        0);
      v(1, 32'h200, 32'h11223344,  4'h3, 0, 32'h0,   4'h0, 0, 1, 0, 32'h0,   32'h0,        4'h0, 32'h0,        0);
      v(1, 32'h200, 32'hAABBCCDD,  4'h6, 0, 32'h202, 4'hF, 1, 1, 1, 32'h200, 32'h11223344, 4'h3, 32'h00003344, 0);
      v(0, 32'h0,   32'h0,         4'h0, 0, 32'h202, 4'hF, 2, 1, 1, 32'h200, 32'h11223344, 4'h7, 32'h00BBCC44, 0);
      v(0, 32'h0,   32'h0,         4'h0, 1, 32'h202, 4'h3, 2, 1, 1, 32'h200, 32'h11223344, 4'h3, 32'h0000CC44, 1);
      v(0, 32'h0,   32'h0,         4'h0, 1, 32'h200, 4'h3, 1, 1, 1, 32'h200, 32'hAABBCCDD, 4'h2, 32'h0000CC00, 0);
      v(1, 32'h300, 32'hB0,        4'hF, 0, 32'h200, 4'hF, 0, 1, 0, 32'h0,   32'h0,        4'h0, 32'h0,        0);
      v(1, 32'h304, 32'hB1,        4'hF, 0, 32'h0,   4'h0, 1, 1, 1, 32'h300, 32'hB0,       4'h0, 32'h0,        0);
      v(1, 32'h308, 32'hB2,        4'hF, 1, 32'h0,   4'h0, 2, 1, 1, 32'h300, 32'hB0,       4'h0, 32'h0,        0);
      v(0, 32'h0,   32'h0,         4'h0, 1, 32'h0,   4'h0, 2, 1, 1, 32'h304, 32'hB1,       4'h0, 32'h0,        0);
      v(0, 32'h0,   32'h0,         4'h0, 1, 32'h0,   4'h0, 1, 1, 1, 32'h308, 32'hB2,       4'h0, 32'h0,        0);
      v(0, 32'h0,   32'h0,         4'h0, 0, 32'h0,   4'h0, 0, 1, 0, 32'h0,   32'h0,        4'h0, 32'h0,        0);

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].req, vecs[i].addr, vecs[i].wdata, vecs[i].sel, 0, vecs[i].ack,
               vecs[i].ld_addr, vecs[i].ld_sel);
         #1;
         chk($sformatf("v%0d_count", i), bus.stb_count, vecs[i].e_count);
         chk($sformatf("v%0d_ready", i), bus.stb2lsummu_ready, vecs[i].e_ready);
         chk($sformatf("v%0d_dc_req", i), bus.stb2dcache_req, vecs[i].e_req);
         chk($sformatf("v%0d_head_addr", i), bus.stb2dcache_addr, vecs[i].e_haddr);
         chk($sformatf("v%0d_head_data", i), bus.stb2dcache_wdata, vecs[i].e_hdata);
         chk($sformatf("v%0d_fwd_mask", i), bus.stb2lsu_fwd_mask, vecs[i].e_mask);
         chk($sformatf("v%0d_fwd_data", i), bus.stb2lsu_fwd_data, vecs[i].e_fdata);
         chk($sformatf("v%0d_fwd_hit", i), bus.stb2lsu_fwd_hit, vecs[i].e_hit);
      end

      // Fence: three held entries, pushes blocked while they drain.
      for (int i = 0; i < 3; i++) step(1, 32'h500 + 4*i, 32'hC0 + i, 4'hF, 0, 0, 32'h0, 4'h0);
      step(1, 32'h600, 32'hDEAD, 4'hF, 1, 0, 32'h600, 4'hF);
      chk("fence_ready", bus.stb2lsummu_ready, 0);
      for (int i = 0; i < 3; i++) step(1, 32'h600, 32'hDEAD, 4'hF, 1, 1, 32'h600, 4'hF);
      step(0, 32'h0, 32'h0, 4'h0, 1, 0, 32'h0, 4'h0);
      chk("fence_done_at_empty", bus.stb2lsummu_fence_done, 1);
      step(0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, 4'h0);

      // Asynchronous reset with three held entries, asserted between clock edges.
      for (int i = 0; i < 3; i++) step(1, 32'h700 + 4*i, 32'hE0 + i, 4'hF, 0, 0, 32'h0, 4'h0);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 32'h700, 4'hF);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_count", bus.stb_count, 0);
      chk("arst_empty", bus.stb_empty, 1);
      chk("arst_dc_req", bus.stb2dcache_req, 0);
      chk("arst_head_addr", bus.stb2dcache_addr, 0);
      chk("arst_fwd_mask", bus.stb2lsu_fwd_mask, 0);
      chk("arst_fwd_hit", bus.stb2lsu_fwd_hit, 0);
      @(negedge clk);
      rst_n = 1'b1;
      model_q.delete();
      step(1, 32'h800, 32'h12345678, 4'hF, 0, 0, 32'h0, 4'h0);
      step(0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h800, 4'hC);
      chk("arst_first_head", bus.stb2dcache_addr, 32'h800);

      // Random mixed traffic over a small address window for frequent matches and wrap.
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 9) < 7,
              32'h400 + $urandom_range(0, 15),
              $urandom,
              SW'($urandom_range(0, 15)),
              $urandom_range(0, 7) == 0,
              $urandom_range(0, 1) == 1,
              32'h400 + $urandom_range(0, 15),
              SW'($urandom_range(0, 15)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/store_buffer_fwd.md
Name: store_buffer_fwd

Overview:
- Parametrised circular store buffer between LSU/MMU and dcache.
- Successor to the single-pointer store buffer datapath, with:
  - simultaneous push and pop in one cycle;
  - count-based full/empty flags;
  - a req/ack drain handshake to dcache;
  - a fence/drain mode;
  - same-cycle store-to-load forwarding with per-byte, youngest-wins merge.

Parameters:
- BLEN, 4: number of entries; power of 2, at least 2.
- ADDR_WIDTH, 32: address width.
- DATA_WIDTH, 32: data width; multiple of 8.
- BYTE_SEL_WIDTH, DATA_WIDTH/8: byte-enable width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- lsummu2stb_req  in  1  store push request.
- lsummu2stb_addr  in  ADDR_WIDTH  store address.
- lsummu2stb_wdata  in  DATA_WIDTH  store data.
- lsummu2stb_sel_byte  in  BYTE_SEL_WIDTH  store byte enables.
- lsummu2stb_fence  in  1  fence: block pushes and drain the buffer.
- stb2lsummu_ready  out  1  push accepted this cycle when req is high.
- stb2lsummu_fence_done  out  1  fence high and buffer empty.
- stb2dcache_req  out  1  head entry valid.
- stb2dcache_addr  out  ADDR_WIDTH  head address.
- stb2dcache_wdata  out  DATA_WIDTH  head data.
- stb2dcache_sel_byte  out  BYTE_SEL_WIDTH  head byte enables.
- dcache2stb_ack  in  1  head written to dcache; pop.
- lsu2stb_ld_addr  in  ADDR_WIDTH  load address for forwarding lookup.
- lsu2stb_ld_sel_byte  in  BYTE_SEL_WIDTH  bytes the load needs.
- stb2lsu_fwd_data  out  DATA_WIDTH  merged forwarded bytes.
- stb2lsu_fwd_mask  out  BYTE_SEL_WIDTH  bytes supplied by the buffer.
- stb2lsu_fwd_hit  out  1  all requested bytes supplied.
- stb_full  out  1  count == BLEN.
- stb_empty  out  1  count == 0.
- stb_count  out  $clog2(BLEN)+1  number of occupied entries.

Behaviour:
- State:
  - wr_ptr and rd_ptr, each $clog2(BLEN) bits, wrap naturally modulo BLEN.
  - count register, $clog2(BLEN)+1 bits.
  - per-entry addr, data and sel storage.
- Reset (async, rst_n low):
  - pointers, count and all valid bits clear to 0.
  - stb_empty=1; stb_full=0; stb_count=0.
  - stb2dcache_req=0; stb2dcache_* data outputs=0.
  - fwd_mask=0; fwd_data=0; fwd_hit=0.
  - Reset asserted mid-operation discards all entries; no partial state survives.
- Ready and push:
  - stb2lsummu_ready = !stb_full && !lsummu2stb_fence. No combinational path from ack.
  - push = req && ready. On push, entry[wr_ptr] is written and wr_ptr increments.
- Drain and pop:
  - stb2dcache_req = !stb_empty.
  - Head fields come combinationally from entry[rd_ptr]; they read 0 when empty.
  - pop = stb2dcache_req && dcache2stb_ack. On pop, rd_ptr increments.
  - ack while empty is ignored.
  - req stays high and head fields stay stable until ack.
- Count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged. Legal even when full is impossible, since ready=0 when full. Legal when count=1.
- Latency:
  - A pushed entry appears at the head or in forwarding from the next cycle.
  - When empty, a push yields stb2dcache_req=1 the following cycle.
- Fence:
  - While lsummu2stb_fence=1, pushes are blocked and draining continues.
  - fence_done = fence && stb_empty; combinational.
- Forwarding (combinational, same cycle):
  - Word match: compare addr[ADDR_WIDTH-1:$clog2(BYTE_SEL_WIDTH)] of every valid entry against the load address.
  - Per byte b: take the youngest matching valid entry with sel[b]=1, ordered from rd_ptr upward to wr_ptr-1 with wrap.
    - fwd_mask[b] = that byte is found AND ld_sel[b]=1.
    - fwd_data byte b = the found byte; 0 when fwd_mask[b]=0.
  - fwd_hit = (ld_sel != 0) && ((fwd_mask & ld_sel) == ld_sel).
  - Entry being pushed this cycle: not visible.
  - Entry being popped this cycle: still visible.
  - Empty buffer: mask=0, hit=0.

Test Plan:
- Reset, then push 4 stores (addr 0x100/0x104/0x108/0x10C, data 0xA0..0xA3, sel 0xF) with ack=0 -> stb_full=1, ready=0, count=4; a 5th req is not accepted.
- Full buffer, assert ack every cycle -> head outputs 0x100, 0x104, 0x108, 0x10C in order; empty=1 after the 4th pop; req=0.
- count=2, push and ack in the same cycle -> count stays 2; order preserved. Run 3×BLEN mixed push/pop cycles to cover wr_ptr/rd_ptr wrap; drained order matches a FIFO model.
- Forwarding merge:
  - Setup: push {0x200, 0x11223344, sel 0x3}, then {0x200, 0xAABBCCDD, sel 0x6}.
  - Load 0x202, ld_sel 0xF -> mask=0x7, data=0x00BBCC44, hit=0.
  - Load with ld_sel 0x3 -> hit=1, data=0x0000CC44.
- Fence: 3 entries held, fence=1 -> ready=0 and push ignored; acks drain the buffer; fence_done=1 in the cycle empty=1.
- Reset mid-operation: rst_n pulsed low asynchronously with 3 entries held -> outputs go to reset values immediately, without a clock edge; after release count=0, and the first new push lands at the head.
